// File: rtl/vram_arbiter_if.sv
// Request/response and BRAM port bundle between the VRAM requesters and vram_arbiter.
// slave = arbiter view, master = requester/BRAM view.
interface vram_arbiter_if #(
    parameter int ADDR_W = 11
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_rvalid;
    logic [31:0]       vid_rdata;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_wstrb;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;

    logic              bram_en;
    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_wdata;
    logic [31:0]       bram_rdata;

    modport slave (
        input  vid_req, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        input  bram_rdata,
        output vid_gnt, vid_rvalid, vid_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output bram_en, bram_we, bram_addr, bram_wdata
    );

    modport master (
        output vid_req, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        output bram_rdata,
        input  vid_gnt, vid_rvalid, vid_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  bram_en, bram_we, bram_addr, bram_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video has priority, a CPU wait counter forces a CPU slot,
// and a tag pipeline steers read data back to its owner.
module vram_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DEPTH    = 601,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic           axi_aclk,
    input  logic           axi_aresetn,
    vram_arbiter_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        WAIT_LIM  = 3'(MAX_WAIT);

    typedef struct packed {
        logic valid;
        logic owner_cpu;
        logic zero;
    } tag_t;

    logic              w_vid_gnt;
    logic              w_cpu_gnt;
    logic              w_cpu_oor;
    logic [2:0]        r_cpu_wait;
    logic              r_bram_en;
    logic [3:0]        r_bram_we;
    logic [ADDR_W-1:0] r_bram_addr;
    logic [31:0]       r_bram_wdata;
    logic [31:0]       r_vid_rdata;
    logic [31:0]       r_cpu_rdata;
    tag_t [RD_LAT:0]   r_tag;

    assign w_cpu_oor = (bus.cpu_addr > LAST_ADDR);

    always_comb begin
        w_vid_gnt = 1'b0;
        w_cpu_gnt = 1'b0;
        if (axi_aresetn) begin
            if (bus.cpu_req && (r_cpu_wait >= WAIT_LIM)) begin
                w_cpu_gnt = 1'b1;
            end else if (bus.vid_req) begin
                w_vid_gnt = 1'b1;
            end else if (bus.cpu_req) begin
                w_cpu_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            r_cpu_wait   <= 3'd0;
            r_bram_en    <= 1'b0;
            r_bram_we    <= 4'h0;
            r_bram_addr  <= '0;
            r_bram_wdata <= 32'h0;
            r_vid_rdata  <= 32'h0;
            r_cpu_rdata  <= 32'h0;
            r_tag        <= '0;
        end else begin
            if (!bus.cpu_req || w_cpu_gnt) begin
                r_cpu_wait <= 3'd0;
            end else if (r_cpu_wait != 3'd7) begin
                r_cpu_wait <= r_cpu_wait + 3'd1;
            end

            // Out-of-range CPU accesses are granted but never reach the BRAM.
            r_bram_en <= w_vid_gnt | (w_cpu_gnt & ~w_cpu_oor);
            r_bram_we <= (w_cpu_gnt && bus.cpu_we && !w_cpu_oor) ? bus.cpu_wstrb : 4'h0;
            if (w_vid_gnt) begin
                r_bram_addr <= bus.vid_addr;
            end else if (w_cpu_gnt) begin
                r_bram_addr <= bus.cpu_addr;
                if (bus.cpu_we) begin
                    r_bram_wdata <= bus.cpu_wdata;
                end
            end

            r_tag[0] <= {w_vid_gnt | (w_cpu_gnt & ~bus.cpu_we), w_cpu_gnt, w_cpu_gnt & w_cpu_oor};
            for (int i = 1; i <= RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end

            if (r_tag[RD_LAT-1].valid) begin
                if (r_tag[RD_LAT-1].owner_cpu) begin
                    r_cpu_rdata <= r_tag[RD_LAT-1].zero ? 32'h0 : bus.bram_rdata;
                end else begin
                    r_vid_rdata <= bus.bram_rdata;
                end
            end
        end
    end

    assign bus.vid_gnt    = w_vid_gnt;
    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.vid_rvalid = r_tag[RD_LAT].valid & ~r_tag[RD_LAT].owner_cpu;
    assign bus.cpu_rvalid = r_tag[RD_LAT].valid & r_tag[RD_LAT].owner_cpu;
    assign bus.vid_rdata  = r_vid_rdata;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.bram_en    = r_bram_en;
    assign bus.bram_we    = r_bram_we;
    assign bus.bram_addr  = r_bram_addr;
    assign bus.bram_wdata = r_bram_wdata;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural BRAM whose data is valid the cycle
// after bram_en (RD_LAT cycles after the grant).
module tb_vram_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] mem [0:2047];

    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(11)) bus ();

    vram_arbiter #(
        .ADDR_W(11), .DEPTH(601), .RD_LAT(2), .MAX_WAIT(4)
    ) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .bus         (bus)
    );

    // BRAM model; contents re-initialise to 0x5A000000+addr while reset is low.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'h5A00_0000 + 32'(i);
            bus.bram_rdata <= 32'h0;
        end else if (bus.bram_en) begin
            bus.bram_rdata <= mem[bus.bram_addr];
            for (int b = 0; b < 4; b++) begin
                if (bus.bram_we[b]) mem[bus.bram_addr][8*b +: 8] <= bus.bram_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic cpu_wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic en_exp);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a;
        bus.cpu_wdata = d;  bus.cpu_wstrb = s;
        mid();
        chk("wr_gnt", {bus.vid_gnt, bus.cpu_gnt}, 2'b01);
        step();
        bus.cpu_req = 1'b0;
        mid();
        chk("wr_en_we", {bus.bram_en, bus.bram_we}, en_exp ? {1'b1, s} : 5'h0);
        if (en_exp) chk("wr_addr_data", {bus.bram_addr, bus.bram_wdata}, {a, d});
        chk("wr_no_rv", {bus.vid_rvalid, bus.cpu_rvalid}, 2'b00);
        step();
        mid();
        chk("wr_en_1cyc", bus.bram_en, 1'b0);
        step();
    endtask

    task automatic cpu_rd(input logic [10:0] a, input logic [31:0] exp, input logic en_exp,
                          input logic [31:0] prev);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
        mid();
        chk("rd_gnt", {bus.vid_gnt, bus.cpu_gnt}, 2'b01);
        step();
        bus.cpu_req = 1'b0;
        mid();
        chk("rd_en_we", {bus.bram_en, bus.bram_we}, {en_exp, 4'h0});
        step();
        mid();
        chk("rd_early", {bus.cpu_rvalid, bus.cpu_rdata}, {1'b0, prev});
        step();
        mid();
        chk("rd_data", {bus.vid_rvalid, bus.cpu_rvalid, bus.cpu_rdata}, {2'b01, exp});
        step();
        mid();
        chk("rd_hold", {bus.cpu_rvalid, bus.cpu_rdata}, {1'b0, exp});
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.vid_req = 1'b1; bus.vid_addr = '0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
        bus.cpu_wdata = '0; bus.cpu_wstrb = '0;

        // 1: reset state, grants blocked during reset, then idle
        repeat (3) step();
        mid();
        chk("rst_gnt", {bus.vid_gnt, bus.cpu_gnt}, 2'b00);
        chk("rst_bram", {bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata}, '0);
        chk("rst_rdata", {bus.vid_rvalid, bus.cpu_rvalid, bus.vid_rdata, bus.cpu_rdata}, '0);
        step();
        bus.vid_req = 1'b0; bus.cpu_req = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mid();
            chk("idle", {bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata,
                         bus.vid_rvalid, bus.cpu_rvalid, bus.vid_gnt, bus.cpu_gnt}, '0);
            step();
        end

        // 2: CPU write then read back
        cpu_wr(11'd5, 32'hDEADBEEF, 4'hF, 1'b1);
        cpu_rd(11'd5, 32'hDEADBEEF, 1'b1, 32'h0);

        // 3: sustained video with a pending CPU read of addr 3
        bus.vid_req = 1'b1; bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 11'd3;
        for (int i = 0; i < 8; i++) begin
            bus.vid_addr = 11'(10 + i);
            mid();
            chk("arb_gnt", {bus.vid_gnt, bus.cpu_gnt}, (i == 4) ? 2'b01 : 2'b10);
            chk("arb_vrv", bus.vid_rvalid, (i >= 3 && i != 7));
            chk("arb_crv", bus.cpu_rvalid, (i == 7));
            if (i == 7) chk("arb_cdata", bus.cpu_rdata, 32'h5A00_0003);
            step();
            if (i == 4) bus.cpu_req = 1'b0;
        end
        bus.vid_req = 1'b0;
        repeat (4) step();

        // 4: partial write at the last word, out-of-range read/write
        cpu_wr(11'd600, 32'hAABBCCDD, 4'h2, 1'b1);
        mid();
        chk("strb_mem", mem[600], 32'h5A00_CC58);
        step();
        cpu_rd(11'd600, 32'h5A00_CC58, 1'b1, 32'h5A00_0003);
        cpu_rd(11'd601, 32'h0, 1'b0, 32'h5A00_CC58);
        cpu_wr(11'd700, 32'hFFFFFFFF, 4'hF, 1'b0);

        // 5: alternating video/CPU reads every cycle
        for (int t = 0; t < 10; t++) begin
            bus.vid_req  = (t < 6) && (t % 2 == 0);
            bus.cpu_req  = (t < 6) && (t % 2 == 1);
            bus.cpu_we   = 1'b0;
            bus.vid_addr = 11'(20 + t);
            bus.cpu_addr = 11'(20 + t);
            mid();
            chk("alt_gnt", {bus.vid_gnt, bus.cpu_gnt}, {bus.vid_req, bus.cpu_req});
            if (t >= 3 && t <= 8) begin
                if ((t - 3) % 2 == 0)
                    chk("alt_vid", {bus.vid_rvalid, bus.cpu_rvalid, bus.vid_rdata},
                        {2'b10, 32'(32'h5A00_0014 + 32'(t - 3))});
                else
                    chk("alt_cpu", {bus.vid_rvalid, bus.cpu_rvalid, bus.cpu_rdata},
                        {2'b01, 32'(32'h5A00_0014 + 32'(t - 3))});
            end else begin
                chk("alt_quiet", {bus.vid_rvalid, bus.cpu_rvalid}, 2'b00);
            end
            step();
        end
        bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
        repeat (2) step();

        // 6: reset right after a video grant kills the in-flight read
        bus.vid_req = 1'b1; bus.vid_addr = 11'd30;
        mid();
        chk("rst6_gnt", {bus.vid_gnt, bus.cpu_gnt}, 2'b10);
        step();
        bus.vid_req = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mid();
            chk("rst6_norv", {bus.vid_rvalid, bus.vid_rdata}, '0);
            step();
        end
        bus.vid_req = 1'b1; bus.vid_addr = 11'd31;
        mid();
        chk("post_gnt", {bus.vid_gnt, bus.cpu_gnt}, 2'b10);
        step();
        bus.vid_req = 1'b0;
        mid();
        chk("post_bram", {bus.bram_en, bus.bram_we, bus.bram_addr}, {1'b1, 4'h0, 11'd31});
        step();
        mid();
        chk("post_early", bus.vid_rvalid, 1'b0);
        step();
        mid();
        chk("post_data", {bus.vid_rvalid, bus.cpu_rvalid, bus.vid_rdata}, {2'b10, 32'h5A00_001F});
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
